// File: rtl/brent_kung_adder_pipe.sv
// ---------------------------------------------------------------------------
// brent_kung_adder_pipe
//
// Pipelined Brent-Kung adder/subtractor with a valid/ready stream on both
// sides. The prefix computation is split into pre-processing (P/G), up-sweep,
// and down-sweep plus sum XOR. Register stages are placed between these
// phases according to PIPE_STAGES.
//
// Parameters
//   WIDTH        operand width, power of two, 4..128
//   PIPE_STAGES  register stages = latency in cycles, 1..3
//
// Ports
//   clk_i        core clock, rising edge
//   rst_ni       asynchronous active-low reset
//   valid_i      operands/mode valid
//   ready_o      block can accept this cycle
//   op1_i/op2_i  operands
//   carry_i      carry-in (ignored when sub_i = 1)
//   sub_i        0: op1 + op2 + carry_i, 1: op1 - op2
//   valid_o      result valid
//   ready_i      downstream accepts result
//   sum_o        result modulo 2^WIDTH
//   carry_o      carry-out; for subtract 1 means no borrow
//   overflow_o   signed overflow, only when BK_ADDER_OVERFLOW_EN is defined
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. ready never depends on the valid presented on the same port.
// Each stage k has a valid bit; it can load when it is empty or when every
// later stage is able to move, so ready_o reaches back from ready_i
// combinationally and empty stages collapse bubbles.
// ---------------------------------------------------------------------------
module brent_kung_adder_pipe #(
    parameter int WIDTH       = 32,
    parameter int PIPE_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] op1_i,
    input  logic [WIDTH-1:0] op2_i,
    input  logic             carry_i,
    input  logic             sub_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
`ifdef BK_ADDER_OVERFLOW_EN
    ,
    output logic             overflow_o
`endif
);

    localparam int LOG = $clog2(WIDTH);

    // Up-sweep: after level lv every node i with (i+1) divisible by 2^lv holds
    // the group generate/propagate of the 2^lv bits ending at i.
    function automatic logic [2*WIDTH-1:0] f_up_sweep(input logic [WIDTH-1:0] g_in,
                                                      input logic [WIDTH-1:0] p_in);
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        g = g_in;
        p = p_in;
        for (int lv = 1; lv <= LOG; lv++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (((i + 1) % (1 << lv)) == 0) begin
                    g[i] = g[i] | (p[i] & g[i - (1 << (lv - 1))]);
                    p[i] = p[i] & p[i - (1 << (lv - 1))];
                end
            end
        end
        return {g, p};
    endfunction

    // Down-sweep: fills in the remaining prefixes so g[i] becomes the carry
    // out of bit i (carry-in is already folded into bit 0).
    function automatic logic [WIDTH-1:0] f_down_sweep(input logic [WIDTH-1:0] g_in,
                                                      input logic [WIDTH-1:0] p_in);
        logic [WIDTH-1:0] g;
        g = g_in;
        for (int lv = LOG - 1; lv >= 1; lv--) begin
            for (int i = (1 << lv) + (1 << (lv - 1)) - 1; i < WIDTH; i += (1 << lv)) begin
                g[i] = g[i] | (p_in[i] & g[i - (1 << (lv - 1))]);
            end
        end
        return g;
    endfunction

    // ------------------------------------------------------------------ handshake
    logic [PIPE_STAGES-1:0] r_v;
    logic [PIPE_STAGES-1:0] w_rdy;
    logic [PIPE_STAGES-1:0] w_up_v;
    logic [PIPE_STAGES-1:0] w_ld;

    for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_hs
        // Stage k may load if any stage from k onward is empty or ready_i is high.
        assign w_rdy[k] = ready_i || !(&r_v[PIPE_STAGES-1:k]);
        if (k == 0) begin : g_first
            assign w_up_v[k] = valid_i;
        end else begin : g_next
            assign w_up_v[k] = r_v[k-1];
        end
        assign w_ld[k] = w_up_v[k] && w_rdy[k];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_v[k] <= 1'b0;
            end else if (w_rdy[k]) begin
                r_v[k] <= w_up_v[k];
            end
        end
    end

    assign ready_o = w_rdy[0];
    assign valid_o = r_v[PIPE_STAGES-1];

    // ------------------------------------------------------------ pre-processing
    logic [WIDTH-1:0] w_b;
    logic             w_cin;
    logic [WIDTH-1:0] w_pre_p;
    logic [WIDTH-1:0] w_pre_g;

    assign w_b     = sub_i ? ~op2_i : op2_i;
    assign w_cin   = sub_i | carry_i;
    assign w_pre_p = op1_i ^ w_b;
    // Fold carry-in into bit 0 so every prefix g is a true carry.
    assign w_pre_g = (op1_i & w_b) | {{(WIDTH-1){1'b0}}, w_pre_p[0] & w_cin};

    // Up-sweep inputs: registered only with three stages.
    logic [WIDTH-1:0] w_us_p;
    logic [WIDTH-1:0] w_us_g;
    logic             w_us_cin;

    if (PIPE_STAGES == 3) begin : g_pre_reg
        logic [WIDTH-1:0] r_pre_p;
        logic [WIDTH-1:0] r_pre_g;
        logic             r_pre_cin;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_pre_p   <= '0;
                r_pre_g   <= '0;
                r_pre_cin <= 1'b0;
            end else if (w_ld[0]) begin
                r_pre_p   <= w_pre_p;
                r_pre_g   <= w_pre_g;
                r_pre_cin <= w_cin;
            end
        end
        assign w_us_p   = r_pre_p;
        assign w_us_g   = r_pre_g;
        assign w_us_cin = r_pre_cin;
    end else begin : g_pre_comb
        assign w_us_p   = w_pre_p;
        assign w_us_g   = w_pre_g;
        assign w_us_cin = w_cin;
    end

    // ------------------------------------------------------------------ up-sweep
    logic [WIDTH-1:0] w_up_g;
    logic [WIDTH-1:0] w_up_p;
    assign {w_up_g, w_up_p} = f_up_sweep(w_us_g, w_us_p);

    // Down-sweep inputs: registered with two or three stages. The raw bit
    // propagates travel alongside for the final XOR.
    logic [WIDTH-1:0] w_ds_g;
    logic [WIDTH-1:0] w_ds_gp;
    logic [WIDTH-1:0] w_ds_p;
    logic             w_ds_cin;

    if (PIPE_STAGES >= 2) begin : g_up_reg
        logic [WIDTH-1:0] r_up_g;
        logic [WIDTH-1:0] r_up_gp;
        logic [WIDTH-1:0] r_up_p;
        logic             r_up_cin;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_up_g   <= '0;
                r_up_gp  <= '0;
                r_up_p   <= '0;
                r_up_cin <= 1'b0;
            end else if (w_ld[PIPE_STAGES-2]) begin
                r_up_g   <= w_up_g;
                r_up_gp  <= w_up_p;
                r_up_p   <= w_us_p;
                r_up_cin <= w_us_cin;
            end
        end
        assign w_ds_g   = r_up_g;
        assign w_ds_gp  = r_up_gp;
        assign w_ds_p   = r_up_p;
        assign w_ds_cin = r_up_cin;
    end else begin : g_up_comb
        assign w_ds_g   = w_up_g;
        assign w_ds_gp  = w_up_p;
        assign w_ds_p   = w_us_p;
        assign w_ds_cin = w_us_cin;
    end

    // ------------------------------------------------- down-sweep and post XOR
    logic [WIDTH-1:0] w_c;
    logic [WIDTH-1:0] w_sum;
    assign w_c   = f_down_sweep(w_ds_g, w_ds_gp);
    assign w_sum = w_ds_p ^ {w_c[WIDTH-2:0], w_ds_cin};

    // ------------------------------------------------------------ output stage
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sum   <= '0;
            r_carry <= 1'b0;
        end else if (w_ld[PIPE_STAGES-1]) begin
            r_sum   <= w_sum;
            r_carry <= w_c[WIDTH-1];
        end
    end

    assign sum_o   = r_sum;
    assign carry_o = r_carry;

`ifdef BK_ADDER_OVERFLOW_EN
    // Signed overflow: carry into MSB differs from carry out of MSB.
    logic r_ovf;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ovf <= 1'b0;
        end else if (w_ld[PIPE_STAGES-1]) begin
            r_ovf <= w_c[WIDTH-1] ^ w_c[WIDTH-2];
        end
    end
    assign overflow_o = r_ovf;
`endif

endmodule

// File: tb/tb_brent_kung_adder_pipe.sv
module tb_brent_kung_adder_pipe;

  localparam int WIDTH       = 32;
  localparam int PIPE_STAGES = 2;

  // ---------------------------------------------------------- clock / reset
  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic             valid_i = 1'b0;
  logic             ready_o;
  logic [WIDTH-1:0] op1_i   = '0;
  logic [WIDTH-1:0] op2_i   = '0;
  logic             carry_i = 1'b0;
  logic             sub_i   = 1'b0;
  logic             valid_o;
  logic             ready_i = 1'b1;
  logic [WIDTH-1:0] sum_o;
  logic             carry_o;
`ifdef BK_ADDER_OVERFLOW_EN
  logic             overflow_o;
`endif

  brent_kung_adder_pipe #(.WIDTH(WIDTH), .PIPE_STAGES(PIPE_STAGES)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .op1_i     (op1_i),
    .op2_i     (op2_i),
    .carry_i   (carry_i),
    .sub_i     (sub_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .sum_o     (sum_o),
    .carry_o   (carry_o)
`ifdef BK_ADDER_OVERFLOW_EN
    ,
    .overflow_o(overflow_o)
`endif
  );

  // ------------------------------------------------------------- scoreboard
  logic [WIDTH:0] exp_q[$];   // {carry, sum}
  logic           ovf_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [WIDTH+1:0] act, input logic [WIDTH+1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on WIDTH+2 bit values.
  // Returns {overflow, carry, sum}.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic c, input logic s);
    logic [WIDTH:0]   u;
    logic [WIDTH+1:0] sa, sb, sr;
    logic             cy, ov;
    sa = {{2{a[WIDTH-1]}}, a};
    sb = {{2{b[WIDTH-1]}}, b};
    if (s) begin
      u  = {1'b0, a} - {1'b0, b};
      cy = (a >= b);
      sr = sa - sb;
    end else begin
      u  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
      cy = u[WIDTH];
      sr = sa + sb + {{(WIDTH+1){1'b0}}, c};
    end
    // Signed result fits in WIDTH bits only if the top three bits agree.
    ov = !((sr[WIDTH+1] == sr[WIDTH]) && (sr[WIDTH] == sr[WIDTH-1]));
    return {ov, cy, u[WIDTH-1:0]};
  endfunction

  task automatic push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c, input logic s);
    logic [WIDTH+1:0] m;
    m = model(a, b, c, s);
    exp_q.push_back(m[WIDTH:0]);
    ovf_q.push_back(m[WIDTH+1]);
  endtask

  // ---------------------------------------------------------------- monitor
  logic           prev_stall = 1'b0;
  logic [WIDTH:0] prev_out   = '0;

  initial begin
    logic [WIDTH:0] e;
    logic           eo;
    forever begin
      @(negedge clk_i);
      #2;
      if (!rst_ni) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall)
          check("hold_while_stalled", {valid_o, carry_o, sum_o}, {1'b1, prev_out});
        if (valid_o && ready_i) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_output: got sum 0x%0h with no result pending at %0t", sum_o, $time);
          end else begin
            e  = exp_q.pop_front();
            eo = ovf_q.pop_front();
            check("result", {1'b0, carry_o, sum_o}, {1'b0, e});
`ifdef BK_ADDER_OVERFLOW_EN
            check("overflow", {{(WIDTH+1){1'b0}}, overflow_o}, {{(WIDTH+1){1'b0}}, eo});
`else
            if (eo === 1'bx) $display("note: undefined overflow reference");
`endif
          end
        end
        prev_stall = valid_o && !ready_i;
        prev_out   = {carry_o, sum_o};
      end
    end
  end

  // ----------------------------------------------------------------- driver
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c, input logic s);
    int guard;
    guard   = 0;
    op1_i   = a;
    op2_i   = b;
    carry_i = c;
    sub_i   = s;
    valid_i = 1'b1;
    #1;
    while (!ready_o && guard < 200) begin
      @(negedge clk_i);
      #1;
      guard++;
    end
    if (!ready_o) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: ready_o stayed 0 for %0d cycles", guard);
    end else begin
      push(a, b, c, s);
    end
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard   = 0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clk_i);
      #3;
      guard++;
    end
    check("drain_empty", (WIDTH+2)'(exp_q.size()), '0);
    @(negedge clk_i);
  endtask

  task automatic latency_test(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c, input logic s);
    int k;
    drain();
    send(a, b, c, s);
    k = 1;
    #1;
    while (!valid_o && k < 20) begin
      @(negedge clk_i);
      #1;
      k++;
    end
    check("latency", (WIDTH+2)'(k), (WIDTH+2)'(PIPE_STAGES));
  endtask

  function automatic logic [WIDTH-1:0] rand_op();
    logic [WIDTH-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = '0;
      1:       v = '1;
      2:       v = {1'b0, {(WIDTH-1){1'b1}}};
      3:       v = {1'b1, {(WIDTH-1){1'b0}}};
      default: v = WIDTH'($urandom);
    endcase
    return v;
  endfunction

  // ------------------------------------------------------------------- main
  initial begin
    int accepted;
    int idx;

    // Reset held for three cycles.
    repeat (3) begin
      @(negedge clk_i);
      #1;
      check("reset_ctrl", {{(WIDTH-1){1'b0}}, valid_o, carry_o, ready_o}, (WIDTH+2)'(1));
      check("reset_sum", {2'b00, sum_o}, '0);
`ifdef BK_ADDER_OVERFLOW_EN
      check("reset_ovf", {{(WIDTH+1){1'b0}}, overflow_o}, '0);
`endif
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
    #1;
    check("post_reset_ctrl", {{(WIDTH-1){1'b0}}, valid_o, carry_o, ready_o}, (WIDTH+2)'(1));
    check("post_reset_sum", {2'b00, sum_o}, '0);

    // Directed vectors, each with a latency measurement.
    latency_test(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    latency_test(32'd5, 32'd7, 1'b1, 1'b1);
    latency_test(32'd7, 32'd5, 1'b0, 1'b1);
    latency_test(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    latency_test(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    latency_test(32'd3, 32'd4, 1'b0, 1'b0);

    // Backpressure: stream 1..4 while the sink stalls.
    drain();
    ready_i  = 1'b0;
    accepted = 0;
    idx      = 1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      op1_i   = WIDTH'(idx);
      op2_i   = '0;
      carry_i = 1'b0;
      sub_i   = 1'b0;
      valid_i = 1'b1;
      #1;
      if (ready_o) begin
        push(WIDTH'(idx), '0, 1'b0, 1'b0);
        idx++;
        accepted++;
      end
      @(negedge clk_i);
    end
    #1;
    check("bp_accepted", (WIDTH+2)'(accepted), (WIDTH+2)'(PIPE_STAGES));
    check("bp_ready_low", {{(WIDTH+1){1'b0}}, ready_o}, '0);
    ready_i = 1'b1;
    while (idx <= 4) begin
      send(WIDTH'(idx), '0, 1'b0, 1'b0);
      idx++;
    end
    drain();

    // Reset with results in flight.
    ready_i = 1'b0;
    send(32'd10, 32'd20, 1'b0, 1'b0);
    send(32'd30, 32'd40, 1'b1, 1'b0);
    @(posedge clk_i);
    #3;
    check("inflight_valid", {{(WIDTH+1){1'b0}}, valid_o}, (WIDTH+2)'(1));
    rst_ni = 1'b0;
    #1;
    check("async_reset_valid", {{(WIDTH-1){1'b0}}, valid_o, carry_o, ready_o}, (WIDTH+2)'(1));
    check("async_reset_sum", {2'b00, sum_o}, '0);
    exp_q.delete();
    ovf_q.delete();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni  = 1'b1;
    ready_i = 1'b1;
    repeat (8) @(negedge clk_i);
    latency_test(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);

    // Randomized traffic with random sink stalls.
    for (int cyc = 0; cyc < 600; cyc++) begin
      ready_i = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 99) < 75) begin
        op1_i   = rand_op();
        op2_i   = rand_op();
        carry_i = 1'($urandom_range(0, 1));
        sub_i   = 1'($urandom_range(0, 1));
        valid_i = 1'b1;
      end else begin
        valid_i = 1'b0;
      end
      #1;
      if (valid_i && ready_o) push(op1_i, op2_i, carry_i, sub_i);
      @(negedge clk_i);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
